tick_timer: RTL

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer_pkg.sv | 22 ++
 rtl/tick_timer_sync.sv | 26 ++
 rtl/tick_timer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tick_timer_pkg.sv
// Shared register map, control/status bit positions and FSM encodings for tick_timer.
package tick_timer_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_RUN      = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_PERIODIC = 2;

   localparam int STAT_TIMEOUT  = 0;
   localparam int STAT_RUNNING  = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2
   } state_e;

endpackage

// File: rtl/tick_timer_sync.sv
// Synchronizes the asynchronous divider tick and emits one registered Clk pulse per rising edge.
module tick_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic async_in,
   output logic pulse_out
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync_q    <= '0;
         hist_q    <= 1'b0;
         pulse_out <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q    <= sync_q[SYNC_STAGES-1];
         pulse_out <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

endmodule

// File: rtl/tick_timer.sv
// Tick-driven down-counter timer with Avalon-MM register access and timeout interrupt.
//
// state    | meaning
// ST_IDLE  | stopped, divider disabled, ticks ignored
// ST_ARM   | load COUNT from PERIOD, ticks ignored
// ST_COUNT | decrement COUNT per tick, timeout at terminal count
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int PERIOD_W    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        tick_in,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        div_run,
   output logic        irq
);

   state_e                state_q, state_d;
   logic [PERIOD_W-1:0]   period_q;
   logic [PERIOD_W-1:0]   count_q, count_d;
   logic                  irq_en_q, periodic_q;
   logic                  timeout_q, timeout_set;
   logic                  tick;
   logic                  ctrl_wr, status_clr, running;
   logic [31:0]           rd_mux;

   tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .Clk       (Clk),
      .Reset     (Reset),
      .async_in  (tick_in),
      .pulse_out (tick)
   );

   assign ctrl_wr    = write && (address == ADDR_CTRL);
   assign status_clr = write && (address == ADDR_STATUS) && writedata[STAT_TIMEOUT];
   assign running    = (state_q != ST_IDLE);
   assign div_run    = running;
   assign irq        = timeout_q & irq_en_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      timeout_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_wr && writedata[CTRL_RUN] && (period_q != '0))
               state_d = ST_ARM;
         end
         ST_ARM: begin
            count_d = period_q;
            state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (tick) begin
               // <= 1 also catches a zero COUNT so the counter can never wrap
               if (count_q <= PERIOD_W'(1)) begin
                  timeout_set = 1'b1;
                  if (periodic_q && (period_q != '0)) begin
                     count_d = period_q;
                  end else begin
                     count_d = '0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  count_d = count_q - PERIOD_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // an explicit stop overrides everything and freezes COUNT
      if (ctrl_wr && !writedata[CTRL_RUN]) begin
         state_d     = ST_IDLE;
         count_d     = count_q;
         timeout_set = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         period_q   <= '0;
         irq_en_q   <= 1'b0;
         periodic_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         if (write && (address == ADDR_PERIOD))
            period_q <= writedata[PERIOD_W-1:0];
         if (ctrl_wr) begin
            irq_en_q   <= writedata[CTRL_IRQ_EN];
            periodic_q <= writedata[CTRL_PERIODIC];
         end
         timeout_q <= timeout_set | (timeout_q & ~status_clr);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_CTRL: begin
            rd_mux[CTRL_RUN]      = running;
            rd_mux[CTRL_IRQ_EN]   = irq_en_q;
            rd_mux[CTRL_PERIODIC] = periodic_q;
         end
         ADDR_PERIOD: rd_mux = 32'(period_q);
         ADDR_COUNT:  rd_mux = 32'(count_q);
         ADDR_STATUS: begin
            rd_mux[STAT_TIMEOUT] = timeout_q;
            rd_mux[STAT_RUNNING] = running;
         end
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         readdata <= '0;
      else if (read)
         readdata <= rd_mux;
   end

endmodule
